rvvi_packetizer: RTL and testbench

RVVI_PACKETIZER -- requirements
Module: rvvi_packetizer

---
 rtl/rvvi_packetizer_pkg.sv | 42 ++++
 rtl/rvvi_packetizer_if.sv | 12 +
 rtl/rvvi_recfifo.sv | 50 +++++
 rtl/rvvi_packetizer.sv | 162 ++++++++++++++++
 tb/tb_rvvi_packetizer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvvi_packetizer_pkg.sv
// rtl/rvvi_packetizer_pkg.sv - shared types, constants and sizing helpers for the RVVI packetizer
// Purpose: core configuration record, frame header magic, FSM state encoding and
// section word-count helpers used by the packetizer and its bench.
// Ports: none (package).
package rvvi_packetizer_pkg;

  typedef struct packed {
    logic [31:0] XLEN;
  } cvw_t;

  localparam cvw_t DEFAULT_CFG = '{XLEN: 32'd64};

  localparam logic [7:0] HDR_MAGIC = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } state_e;

  function automatic int words32(input int bits);
    return (bits + 31) / 32;
  endfunction

  function automatic int req_w(input int xlen);
    return words32(56 + 3 * xlen);
  endfunction

  function automatic int reg_w(input int xlen);
    return words32(16 + 2 * xlen);
  endfunction

  function automatic int csr_w(input int xlen);
    return words32(xlen + 16);
  endfunction

  localparam int XLEN_DEF = int'(DEFAULT_CFG.XLEN);
  localparam int REQ_W    = req_w(XLEN_DEF);
  localparam int REG_W    = reg_w(XLEN_DEF);
  localparam int CSR_W    = csr_w(XLEN_DEF);

endpackage

// File: rtl/rvvi_packetizer_if.sv
// rtl/rvvi_packetizer_if.sv - 32-bit output stream bundle of the RVVI packetizer
// Purpose: groups the stream handshake signals.
// Ports: TData/TValid/TLast driven by the master, TReady driven by the slave.
interface rvvi_packetizer_if;
  logic [31:0] TData;
  logic        TValid;
  logic        TReady;
  logic        TLast;

  modport master (output TData, output TValid, output TLast, input TReady);
  modport slave  (input TData, input TValid, input TLast, output TReady);
endinterface

// File: rtl/rvvi_recfifo.sv
// rtl/rvvi_recfifo.sv - two-deep record buffer
// Purpose: holds up to two full retired-instruction records.
// Ports: clk, reset (sync active-low), push_i/data_i write, pop_i drops the head,
//        head_o oldest record, next_o record queued behind it, occ_o occupancy 0..2.
module rvvi_recfifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       occ_q;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  // Push while full is only allowed together with a pop, so the write lands
  // in the slot being freed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push_i) wr_q <= ~wr_q;
      if (pop_i)  rd_q <= ~rd_q;
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: ;
      endcase
    end
  end

  assign head_o = mem_q[rd_q];
  assign next_o = mem_q[~rd_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/rvvi_packetizer.sv
// rtl/rvvi_packetizer.sv - frames retired-instruction records onto a 32-bit stream
// Purpose: buffers RVVI records and emits header + Required + Register + CSR words.
// Ports: clk, reset (sync active-low), valid/rvvi record input, RvviStall buffer
//        full, Overflow sticky drop flag, tx output stream (master).
module rvvi_packetizer
  import rvvi_packetizer_pkg::*;
#(
  parameter cvw_t P        = DEFAULT_CFG,
  parameter int   MAX_CSRS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic [72+5*int'(P.XLEN)+MAX_CSRS*(int'(P.XLEN)+16)-1:0] rvvi,
  output logic RvviStall,
  output logic Overflow,
  rvvi_packetizer_if.master tx
);

  localparam int XLEN   = int'(P.XLEN);
  localparam int REQ_B  = 56 + 3 * XLEN;
  localparam int REG_B  = 16 + 2 * XLEN;
  localparam int CSR_B  = XLEN + 16;
  localparam int REC_B  = REQ_B + REG_B + MAX_CSRS * CSR_B;
  localparam int N_REQ  = req_w(XLEN);
  localparam int N_REG  = reg_w(XLEN);
  localparam int N_CSR  = csr_w(XLEN);
  localparam int BODY_W = N_REQ + N_REG + MAX_CSRS * N_CSR;

  typedef logic [REC_B-1:0] rec_t;

  // CSR count lives just below the four zero MSBs of the Required section.
  function automatic logic [11:0] csr_field(input rec_t r);
    return r[REQ_B-5 -: 12];
  endfunction

  function automatic logic [15:0] frame_len(input logic [11:0] field);
    logic [11:0] n;
    n = (field > 12'(MAX_CSRS)) ? 12'(MAX_CSRS) : field;
    return 16'(N_REQ + N_REG) + 16'(n) * 16'(N_CSR);
  endfunction

  function automatic logic [31:0] header_word(input logic [11:0] field, input logic [7:0] seq);
    return {HDR_MAGIC, seq, frame_len(field)};
  endfunction

  // Each section starts on a fresh 32-bit word, upper pad bits zero.
  function automatic logic [31:0] body_word(input rec_t r, input logic [15:0] idx);
    logic [BODY_W*32-1:0] body;
    body = '0;
    body[REQ_B-1:0] = r[REQ_B-1:0];
    body[N_REQ*32 +: REG_B] = r[REQ_B +: REG_B];
    for (int s = 0; s < MAX_CSRS; s++)
      body[(N_REQ+N_REG+s*N_CSR)*32 +: CSR_B] = r[REQ_B+REG_B+s*CSR_B +: CSR_B];
    return body[32*int'(idx) +: 32];
  endfunction

  state_e      state_q;
  logic [31:0] tdata_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic [15:0] cnt_q;
  logic [7:0]  seq_q;
  logic        ovf_q;

  rec_t        head;
  rec_t        nxt;
  logic [1:0]  occ;
  logic        fire;
  logic        final_beat;
  logic        accept;
  logic        push;
  logic [15:0] len_head;
  logic        unused_nxt_bits;

  assign fire       = tvalid_q & tx.TReady;
  assign final_beat = fire & tlast_q;
  assign accept     = (occ != 2'd2) | final_beat;
  assign push       = valid & accept;
  assign len_head   = frame_len(csr_field(head));

  // Only the CSR count of the queued record is needed ahead of time.
  assign unused_nxt_bits = ^{nxt[REC_B-1:REQ_B-4], nxt[REQ_B-17:0]};

  rvvi_recfifo #(.WIDTH(REC_B)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (rvvi),
    .pop_i  (final_beat),
    .head_o (head),
    .next_o (nxt),
    .occ_o  (occ)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      cnt_q    <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (valid && !accept) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (occ != 2'd0) begin
            state_q  <= ST_HEADER;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= header_word(csr_field(head), seq_q);
          end
        end
        ST_HEADER: begin
          if (fire) begin
            state_q <= ST_BODY;
            cnt_q   <= '0;
            tdata_q <= body_word(head, 16'd0);
            tlast_q <= (len_head == 16'd1);
          end
        end
        ST_BODY: begin
          if (fire) begin
            if (tlast_q) begin
              seq_q <= seq_q + 8'd1;
              cnt_q <= '0;
              // Head is popped this edge; a second entry becomes the new head.
              if (occ == 2'd2) begin
                state_q <= ST_HEADER;
                tlast_q <= 1'b0;
                tdata_q <= header_word(nxt[REQ_B-5 -: 12], seq_q + 8'd1);
              end else begin
                state_q  <= ST_IDLE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tdata_q  <= '0;
              end
            end else begin
              cnt_q   <= cnt_q + 16'd1;
              tdata_q <= body_word(head, cnt_q + 16'd1);
              tlast_q <= (cnt_q + 16'd2 == len_head);
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.TData   = tdata_q;
  assign tx.TValid  = tvalid_q;
  assign tx.TLast   = tlast_q;
  assign RvviStall  = (occ == 2'd2);
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_rvvi_packetizer.sv
// tb/tb_rvvi_packetizer.sv - directed self-checking bench for rvvi_packetizer
module tb_rvvi_packetizer;
  import rvvi_packetizer_pkg::*;

  localparam int REC_B = 632;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid;
  logic [REC_B-1:0] rvvi;
  logic             RvviStall;
  logic             Overflow;

  rvvi_packetizer_if tx_if ();

  rvvi_packetizer #(.P(DEFAULT_CFG), .MAX_CSRS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .rvvi      (rvvi),
    .RvviStall (RvviStall),
    .Overflow  (Overflow),
    .tx        (tx_if)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [7:0]       exp_seq;
  logic [REC_B-1:0] rec_v;
  logic [31:0]      exp_q[$];
  logic [31:0]      exp_a[$];
  logic [31:0]      exp_b[$];
  logic [31:0]      got_q[$];
  logic             got_last[$];
  int               beats;
  int               cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Builds rec_v from per-section patterns and the expected frame in exp_q.
  task automatic make_rec(input logic [7:0] tag, input logic [11:0] cntf, input logic [7:0] seq);
    logic [255:0] rq;
    logic [159:0] rg;
    logic [95:0]  cs0, cs1, cs2;
    int n;
    for (int k = 0; k < 8; k++) rq[k*32 +: 32] = {tag, 8'h01, 8'(k), 8'hC3};
    for (int k = 0; k < 5; k++) rg[k*32 +: 32] = {tag, 8'h02, 8'(k), 8'h5A};
    for (int k = 0; k < 3; k++) begin
      cs0[k*32 +: 32] = {tag, 8'h10, 8'(k), 8'h99};
      cs1[k*32 +: 32] = {tag, 8'h11, 8'(k), 8'h99};
      cs2[k*32 +: 32] = {tag, 8'h12, 8'(k), 8'h99};
    end
    rq[255:244] = '0;
    rq[243:232] = cntf;
    rg[159:144] = '0;
    cs0[95:80]  = '0;
    cs1[95:80]  = '0;
    cs2[95:80]  = '0;
    rec_v = {cs2[79:0], cs1[79:0], cs0[79:0], rg[143:0], rq[247:0]};
    n = (cntf > 12'd3) ? 3 : int'(cntf);
    exp_q.delete();
    exp_q.push_back({8'h5A, seq, 16'(13 + 3 * n)});
    for (int k = 0; k < 8; k++) exp_q.push_back(rq[k*32 +: 32]);
    for (int k = 0; k < 5; k++) exp_q.push_back(rg[k*32 +: 32]);
    if (n > 0) for (int k = 0; k < 3; k++) exp_q.push_back(cs0[k*32 +: 32]);
    if (n > 1) for (int k = 0; k < 3; k++) exp_q.push_back(cs1[k*32 +: 32]);
    if (n > 2) for (int k = 0; k < 3; k++) exp_q.push_back(cs2[k*32 +: 32]);
  endtask

  task automatic push_rec();
    valid = 1'b1;
    rvvi  = rec_v;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Entered and left at a negedge; mode 1 toggles TReady starting low.
  task automatic run_frame(input int mode, input string tag);
    bit          done;
    bit          pend;
    logic [31:0] hd;
    logic        hl;
    logic        rdy;
    int          c;
    got_q.delete();
    got_last.delete();
    done = 1'b0;
    pend = 1'b0;
    c    = 0;
    while (!done && c < 200) begin
      rdy = (mode == 0) ? 1'b1 : c[0];
      if (pend) begin
        chk({tag, " hold data"}, tx_if.TData, hd);
        chk({tag, " hold last"}, {31'b0, tx_if.TLast}, {31'b0, hl});
        pend = 1'b0;
      end
      tx_if.TReady = rdy;
      if (tx_if.TValid && rdy) begin
        got_q.push_back(tx_if.TData);
        got_last.push_back(tx_if.TLast);
        if (tx_if.TLast) done = 1'b1;
      end else if (tx_if.TValid) begin
        pend = 1'b1;
        hd   = tx_if.TData;
        hl   = tx_if.TLast;
      end
      c++;
      @(negedge clk);
    end
    chk({tag, " completed"}, {31'b0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s last%0d", tag, i), {31'b0, got_last[i]}, {31'b0, (i == exp_q.size() - 1)});
    end
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    rvvi  = '0;
    tx_if.TReady = 1'b0;
    exp_seq = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset tvalid", {31'b0, tx_if.TValid}, 32'd0);
    chk("reset tlast", {31'b0, tx_if.TLast}, 32'd0);
    chk("reset tdata", tx_if.TData, 32'd0);
    chk("reset stall", {31'b0, RvviStall}, 32'd0);
    chk("reset overflow", {31'b0, Overflow}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single frame, no CSRs, with write + state-transition latency.
    make_rec(8'h11, 12'd0, exp_seq);
    push_rec();
    chk("latency edge1 tvalid", {31'b0, tx_if.TValid}, 32'd0);
    @(negedge clk);
    chk("latency edge2 tvalid", {31'b0, tx_if.TValid}, 32'd1);
    chk("latency edge2 header", tx_if.TData, 32'h5A00000D);
    run_frame(0, "f1");
    check_frame("f1");
    exp_seq++;

    // Two CSR slots: slot 2 must be absent.
    make_rec(8'h22, 12'd2, exp_seq);
    push_rec();
    run_frame(0, "f2");
    chk("f2 header", got_q[0], 32'h5A010013);
    check_frame("f2");
    exp_seq++;

    // CSR count 7 clamps to 3; TReady toggles.
    make_rec(8'h33, 12'd7, exp_seq);
    push_rec();
    run_frame(1, "f3");
    chk("f3 header", got_q[0], 32'h5A020016);
    check_frame("f3");
    exp_seq++;

    // Three valids with sink stalled: third dropped.
    tx_if.TReady = 1'b0;
    make_rec(8'h44, 12'd1, exp_seq);
    exp_a = exp_q;
    valid = 1'b1;
    rvvi  = rec_v;
    @(negedge clk);
    chk("stall after 1st", {31'b0, RvviStall}, 32'd0);
    make_rec(8'h55, 12'd3, exp_seq + 8'd1);
    exp_b = exp_q;
    rvvi  = rec_v;
    @(negedge clk);
    chk("stall after 2nd", {31'b0, RvviStall}, 32'd1);
    chk("overflow before drop", {31'b0, Overflow}, 32'd0);
    make_rec(8'h66, 12'd0, 8'h00);
    rvvi = rec_v;
    @(negedge clk);
    valid = 1'b0;
    chk("overflow after drop", {31'b0, Overflow}, 32'd1);
    chk("stall held", {31'b0, RvviStall}, 32'd1);
    exp_q = exp_a;
    run_frame(0, "fa");
    chk("fa header", got_q[0], 32'h5A030010);
    check_frame("fa");
    exp_seq++;
    chk("back-to-back tvalid", {31'b0, tx_if.TValid}, 32'd1);
    chk("back-to-back header", tx_if.TData, 32'h5A040016);
    exp_q = exp_b;
    run_frame(0, "fb");
    check_frame("fb");
    exp_seq++;
    chk("dropped record absent", {31'b0, tx_if.TValid}, 32'd0);
    chk("overflow sticky", {31'b0, Overflow}, 32'd1);

    // Run frames up to the sequence wrap.
    while (exp_seq != 8'hFF) begin
      make_rec(exp_seq, 12'd0, exp_seq);
      push_rec();
      run_frame(0, "wrap");
      chk("wrap header", got_q[0], exp_q[0]);
      exp_seq++;
    end
    make_rec(8'hFE, 12'd0, exp_seq);
    push_rec();
    run_frame(0, "seqff");
    chk("seq ff header", got_q[0], 32'h5AFF000D);
    check_frame("seqff");
    exp_seq++;
    make_rec(8'hEF, 12'd0, exp_seq);
    push_rec();
    run_frame(0, "seq00");
    chk("seq 00 header", got_q[0], 32'h5A00000D);
    check_frame("seq00");
    exp_seq++;

    // Reset while body word 5 is presented, with a second record buffered.
    tx_if.TReady = 1'b0;
    make_rec(8'h77, 12'd0, exp_seq);
    exp_a = exp_q;
    push_rec();
    make_rec(8'h88, 12'd0, exp_seq + 8'd1);
    push_rec();
    beats = 0;
    cyc   = 0;
    while (beats < 6 && cyc < 50) begin
      tx_if.TReady = 1'b1;
      if (tx_if.TValid) beats++;
      cyc++;
      @(negedge clk);
    end
    chk("pre-reset beats", beats, 32'd6);
    chk("pre-reset word5", tx_if.TData, exp_a[6]);
    chk("pre-reset stall", {31'b0, RvviStall}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid reset tvalid", {31'b0, tx_if.TValid}, 32'd0);
    chk("mid reset tlast", {31'b0, tx_if.TLast}, 32'd0);
    chk("mid reset tdata", tx_if.TData, 32'd0);
    chk("mid reset stall", {31'b0, RvviStall}, 32'd0);
    chk("mid reset overflow", {31'b0, Overflow}, 32'd0);
    repeat (3) @(negedge clk);
    chk("buffer discarded", {31'b0, tx_if.TValid}, 32'd0);
    exp_seq = 8'd0;
    make_rec(8'h99, 12'd0, exp_seq);
    push_rec();
    run_frame(0, "post");
    chk("post-reset header", got_q[0], 32'h5A00000D);
    check_frame("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
